// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem transaction, a single output
// register toward decode, and redirect handling that kills in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_cpu,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_rready_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  // Handshakes: a request transfers on a cycle with imem_req_o && imem_gnt_i; a
  // response transfers on a cycle with imem_rvalid_i && imem_rready_o.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        stale_q, stale_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  logic        gnt_acc;
  logic        resp_acc;
  logic [31:0] redir_pc;

  assign gnt_acc       = (state_q == S_REQ) && imem_gnt_i;
  assign imem_rready_o = !rst_i && (kill_q || !valid_q || !stall_i);
  assign resp_acc      = (state_q == S_WAIT) && imem_rvalid_i && imem_rready_o;
  assign redir_pc      = {redirect_pc_i[31:2], 2'b00};

  // stale_q marks a presented request whose target was redirected before its
  // grant: the old address stays on the bus (held in req_pc_q) until granted.
  assign imem_req_o    = !rst_i && (state_q == S_REQ);
  assign imem_addr_o   = stale_q ? req_pc_q : fetch_pc_q;
  assign inst_valid_o  = valid_q;
  assign inst_o        = inst_q;
  assign pc_o          = pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    kill_d     = kill_q;
    stale_d    = stale_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;

    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (gnt_acc) state_d = S_WAIT;
      S_WAIT:  if (resp_acc) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    if (gnt_acc) begin
      if (stale_q) begin
        kill_d = 1'b1;
      end else begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      stale_d = 1'b0;
    end

    if (resp_acc && kill_q) kill_d = 1'b0;

    if (redirect_valid_i) begin
      fetch_pc_d = redir_pc;
      if (gnt_acc || ((state_q == S_WAIT) && !resp_acc)) kill_d = 1'b1;
      if ((state_q == S_REQ) && !gnt_acc && !stale_q) begin
        stale_d  = 1'b1;
        req_pc_d = fetch_pc_q;
      end
    end

    // A redirect squashes the output register even under stall.
    if (redirect_valid_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (resp_acc && !kill_q) begin
      valid_d = 1'b1;
      inst_d  = imem_rdata_i;
      pc_d    = req_pc_q;
    end else if (valid_q && !stall_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      kill_q     <= 1'b0;
      stale_q    <= 1'b0;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      stale_q    <= stale_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits[1:0] SHALL be 00.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: value driven on inst_o when no valid instruction is held.
REQ-003 clk_cpu  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 stall_i  in  1  downstream stall; output register held while high.
REQ-006 redirect_valid_i  in  1  control-flow redirect from execute (branch/jal/jalr resolved).
REQ-007 redirect_pc_i  in  32  redirect target; bits[1:0] ignored, treated as 00.
REQ-008 imem_req_o  out  1  instruction memory request.
REQ-009 imem_addr_o  out  32  request address, word aligned.
REQ-010 imem_gnt_i  in  1  request accepted this cycle (handshake with imem_req_o).
REQ-011 imem_rvalid_i  in  1  response valid; held by memory until imem_rready_o.
REQ-012 imem_rdata_i  in  32  response instruction word.
REQ-013 imem_rready_o  out  1  response accept.
REQ-014 inst_valid_o  out  1  inst_o/pc_o hold a live instruction for decode.
REQ-015 inst_o  out  32  fetched instruction.
REQ-016 pc_o  out  32  address of inst_o.

Function
REQ-017 States: IDLE, REQ, WAIT; at most one outstanding memory transaction.
REQ-018 IDLE: imem_req_o=0; next cycle -> REQ.
REQ-019 REQ: imem_req_o=1, imem_addr_o=fetch_pc; imem_addr_o stable until imem_gnt_i; on gnt: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), -> WAIT.
REQ-020 WAIT: imem_req_o=0; on imem_rvalid_i && imem_rready_o -> REQ the following cycle (one fetch per 3 cycles minimum with 1-cycle gnt/rvalid).
REQ-021 imem_rready_o = kill || !inst_valid_o || !stall_i.
REQ-022 Response accept with kill=0 and no redirect that cycle: inst_o<=imem_rdata_i, pc_o<=req_pc, inst_valid_o<=1.
REQ-023 Consume: inst_valid_o && !stall_i with no new response that cycle -> inst_valid_o<=0, inst_o<=NOP_INST.
REQ-024 Stall: inst_valid_o && stall_i && no redirect -> inst_o, pc_o, inst_valid_o unchanged.
REQ-025 Redirect (any state except during rst_i): fetch_pc<=redirect_pc_i with bits[1:0]=00, overriding the +4 of REQ-019; inst_valid_o<=0, inst_o<=NOP_INST, regardless of stall_i.
REQ-026 Redirect while a transaction is outstanding (WAIT, or gnt in same cycle) and no response accepted that cycle: kill<=1.
REQ-027 Redirect in REQ without gnt: request continues at old address; kill<=1 on its gnt; next request uses new fetch_pc.
REQ-028 Response accepted with kill=1: data discarded, kill<=0, outputs unchanged by it.
REQ-029 Response accepted in the same cycle as a redirect: data discarded, kill not set.
REQ-030 Further redirects while kill=1: kill stays 1, fetch_pc takes the latest target.

Reset
REQ-031 While rst_i high: state=IDLE, fetch_pc=RESET_PC, req_pc=RESET_PC, kill=0, imem_req_o=0, imem_rready_o=0, inst_valid_o=0, inst_o=NOP_INST, pc_o=RESET_PC.
REQ-032 Reset asserted mid-transaction: outstanding response abandoned; the bench/memory model SHALL drop it; first post-reset request is at RESET_PC.

Verification
REQ-033 Reset release, gnt and rvalid one cycle after each request, stall_i=0 -> requests at 0x0,0x4,0x8; pc_o/inst_o match, inst_valid_o pulses per fetch.
REQ-034 inst_valid_o=1 at pc 0x4, stall_i=1 for 5 cycles, next response ready -> imem_rready_o=0, outputs frozen at 0x4; on stall release 0x8 accepted next cycle.
REQ-035 Redirect to 0x100 while in WAIT for 0x8 -> response for 0x8 discarded, next request addr 0x100, pc_o=0x100 after its response.
REQ-036 Redirect to 0x203 in REQ without gnt, gnt next cycle -> old request completes and is discarded; next request at 0x200.
REQ-037 Redirect concurrent with stall_i=1 and inst_valid_o=1 -> inst_valid_o=0, inst_o=0x00000013 next cycle.
REQ-038 fetch_pc=0xFFFF_FFFC fetched -> next request at 0x0000_0000.
